// File: rtl/hsv_pixel_rx_pkg.sv
// -----------------------------------------------------------------------------
// rps_pkg : shared definitions for the RPS classifier pixel path.
//   Image geometry, the HSV pixel layout and the receive FSM state type.
//   Imported by the serial front end (hsv_pixel_rx) and by the mask/classifier
//   stage downstream.
// -----------------------------------------------------------------------------
package rps_pkg;

    localparam int LENGTH   = 40;   // image rows
    localparam int WIDTH    = 60;   // image columns
    localparam int HSV_BITS = 24;
    localparam int POS_BITS = 6;    // row/column field width

    // Bit order matches the wire: hue arrives first, value last.
    typedef struct packed {
        logic [7:0] value;
        logic [7:0] saturation;
        logic [7:0] hue;
    } hsv_t;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    // True when (row, col) is the final pixel of a length x width frame.
    function automatic logic pos_is_last(input logic [POS_BITS-1:0] row,
                                         input logic [POS_BITS-1:0] col,
                                         input int                  length,
                                         input int                  width);
        return (row == POS_BITS'(length - 1)) && (col == POS_BITS'(width - 1));
    endfunction

endpackage

// File: rtl/hsv_pixel_rx_if.sv
// -----------------------------------------------------------------------------
// hsv_pixel_rx_if : valid/ready pixel stream between the serial front end
// (master) and the hand-mask/classifier stage (slave).
//   pixel_valid  master->slave  output register holds a pixel
//   pixel_ready  slave->master  downstream can accept (may be tied high)
//   pixel_hsv    master->slave  [7:0] hue, [15:8] saturation, [23:16] value
//   pixel_row    master->slave  row of the held pixel
//   pixel_col    master->slave  column of the held pixel
//   pixel_last   master->slave  held pixel is the last of the frame
// -----------------------------------------------------------------------------
interface hsv_pixel_rx_if;
    import rps_pkg::*;

    logic                pixel_valid;
    logic                pixel_ready;
    logic [HSV_BITS-1:0] pixel_hsv;
    logic [POS_BITS-1:0] pixel_row;
    logic [POS_BITS-1:0] pixel_col;
    logic                pixel_last;

    modport master (
        output pixel_valid, pixel_hsv, pixel_row, pixel_col, pixel_last,
        input  pixel_ready
    );

    modport slave (
        input  pixel_valid, pixel_hsv, pixel_row, pixel_col, pixel_last,
        output pixel_ready
    );

endinterface

// File: rtl/hsv_pixel_rx_sync_glitch_filter.sv
// -----------------------------------------------------------------------------
// sync_glitch_filter : brings an asynchronous pin into clk_i and removes
// short pulses.
//   clk_i    system clock
//   rst_n    asynchronous active-low reset
//   pin_i    asynchronous input pin
//   level_o  filtered level (registered)
//   rise_o   one-cycle pulse, registered together with a 0->1 level change
// The level flips only after FILTER_LEN consecutive synchronised samples
// disagree with it; any agreeing sample restarts the count.
// -----------------------------------------------------------------------------
module sync_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;

    // Filter decision: count disagreeing samples, flip the level on a full run.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q[SYNC_STAGES-1] != level_q) begin
            // >= makes the counter saturate even if it were ever past the limit.
            if (cnt_q >= CNT_W'(FILTER_LEN - 1)) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchroniser chain plus filter state registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q[0] <= pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/hsv_pixel_rx.sv
// -----------------------------------------------------------------------------
// hsv_pixel_rx : serial front end of the RPS classifier.
//   fpga_clk     system clock, the only clock
//   rst_n        asynchronous active-low reset
//   pi_clk       Pi bit clock (asynchronous pin, sampled, never used as clock)
//   data_in      Pi serial data (asynchronous pin)
//   err_clr      synchronous clear of the sticky error flags
//   pix          valid/ready pixel stream (master side)
//   overrun      sticky: a completed pixel was dropped
//   timeout_err  sticky: a partial pixel was discarded
// Pixels are assembled LSB-first, 24 bits each, and tagged with row/column.
// Optional feature macro: HSV_PIXEL_RX_TIMEOUT_EN (mid-pixel idle timeout).
// -----------------------------------------------------------------------------
module hsv_pixel_rx
    import rps_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int LENGTH         = rps_pkg::LENGTH,
    parameter int WIDTH          = rps_pkg::WIDTH,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic           fpga_clk,
    input  logic           rst_n,
    input  logic           pi_clk,
    input  logic           data_in,
    input  logic           err_clr,
    hsv_pixel_rx_if.master pix,
    output logic           overrun,
    output logic           timeout_err
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic                  pi_level_s, pi_rise_s;
    logic [SYNC_STAGES-1:0] dsync_q;
    logic [FILTER_LEN-1:0]  ddly_q;

    rx_state_t             state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [22:0]           shift_q, shift_d;
    logic [POS_BITS-1:0]   row_q, row_d, col_q, col_d;
    logic                  valid_q, valid_d;
    hsv_t                  hsv_q, hsv_d;
    logic [POS_BITS-1:0]   orow_q, orow_d, ocol_q, ocol_d;
    logic                  olast_q, olast_d;
    logic                  overrun_q, overrun_d, tout_q, tout_d;

    logic capture_s, done_s, drain_s, load_s, ovr_evt_s, tout_evt_s, bit_s;

    sync_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_pi_clk_filter (
        .clk_i   (fpga_clk),
        .rst_n   (rst_n),
        .pin_i   (pi_clk),
        .level_o (pi_level_s),
        .rise_o  (pi_rise_s)
    );

    // data_in synchroniser followed by a FILTER_LEN delay line so the captured
    // bit lines up with the filtered clock edge.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            dsync_q <= '0;
            ddly_q  <= '0;
        end else begin
            dsync_q[0] <= data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dsync_q[i] <= dsync_q[i-1];
            end
            ddly_q[0] <= dsync_q[SYNC_STAGES-1];
            for (int i = 1; i < FILTER_LEN; i++) begin
                ddly_q[i] <= ddly_q[i-1];
            end
        end
    end

    // The rise pulse and level register on the same edge; requiring both keeps
    // capture tied to a genuine high phase.
    assign capture_s = pi_rise_s && pi_level_s;
    assign bit_s     = ddly_q[FILTER_LEN-1];
    assign done_s    = capture_s && (bit_cnt_q == 5'd23);
    assign drain_s   = valid_q && pix.pixel_ready;
    assign load_s    = done_s && (!valid_q || drain_s);
    assign ovr_evt_s = done_s && !load_s;

`ifdef HSV_PIXEL_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_q, idle_d;

    // Idle counter: runs only mid-pixel, restarts on every captured bit.
    always_comb begin
        idle_d     = '0;
        tout_evt_s = 1'b0;
        if ((state_q == RX_SHIFT) && !capture_s) begin
            if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                tout_evt_s = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end else begin
            idle_d = '0;
        end
    end

    // Idle counter register.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign tout_evt_s = 1'b0;
`endif

    // Receive FSM, position counters and single-entry output register.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        row_d     = row_q;
        col_d     = col_q;
        hsv_d     = hsv_q;
        orow_d    = orow_q;
        ocol_d    = ocol_q;
        olast_d   = olast_q;
        if (drain_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (done_s) begin
            bit_cnt_d = 5'd0;
            state_d   = RX_IDLE;
            if (load_s) begin
                valid_d = 1'b1;
                hsv_d   = {bit_s, shift_q};
                orow_d  = row_q;
                ocol_d  = col_q;
                olast_d = pos_is_last(row_q, col_q, LENGTH, WIDTH);
            end else begin
                valid_d = valid_d;
            end
            // Counters advance even for a dropped pixel to stay frame-aligned.
            if (col_q == POS_BITS'(WIDTH - 1)) begin
                col_d = '0;
                if (row_q == POS_BITS'(LENGTH - 1)) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (capture_s) begin
            shift_d[bit_cnt_q] = bit_s;
            bit_cnt_d          = bit_cnt_q + 5'd1;
            state_d            = RX_SHIFT;
        end else if (tout_evt_s) begin
            bit_cnt_d = 5'd0;
            state_d   = RX_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // Sticky flags: a new event outranks a simultaneous clear.
    assign overrun_d = (overrun_q && !err_clr) || ovr_evt_s;
    assign tout_d    = (tout_q && !err_clr) || tout_evt_s;

    // Main state registers.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= 5'd0;
            shift_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            valid_q   <= 1'b0;
            hsv_q     <= '0;
            orow_q    <= '0;
            ocol_q    <= '0;
            olast_q   <= 1'b0;
            overrun_q <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            row_q     <= row_d;
            col_q     <= col_d;
            valid_q   <= valid_d;
            hsv_q     <= hsv_d;
            orow_q    <= orow_d;
            ocol_q    <= ocol_d;
            olast_q   <= olast_d;
            overrun_q <= overrun_d;
            tout_q    <= tout_d;
        end
    end

    assign pix.pixel_valid = valid_q;
    assign pix.pixel_hsv   = hsv_q;
    assign pix.pixel_row   = orow_q;
    assign pix.pixel_col   = ocol_q;
    assign pix.pixel_last  = olast_q;
    assign overrun         = overrun_q;
    assign timeout_err     = tout_q;

endmodule

// File: tb/tb_hsv_pixel_rx.sv
// -----------------------------------------------------------------------------
// tb_hsv_pixel_rx : directed, table-driven bench for hsv_pixel_rx.
// A reduced 4x5 frame and a 200-cycle timeout keep the run short.
// -----------------------------------------------------------------------------
module tb_hsv_pixel_rx;
    import rps_pkg::*;

    localparam int TB_LENGTH  = 4;
    localparam int TB_WIDTH   = 5;
    localparam int TB_TIMEOUT = 200;
    localparam int HALF       = 8;    // pi_clk phase length in fpga_clk cycles

    logic fpga_clk = 1'b0;
    logic rst_n    = 1'b0;
    logic pi_clk   = 1'b0;
    logic data_in  = 1'b0;
    logic err_clr  = 1'b0;
    logic overrun, timeout_err;

    hsv_pixel_rx_if pix_if();

    hsv_pixel_rx #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .LENGTH         (TB_LENGTH),
        .WIDTH          (TB_WIDTH),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .fpga_clk    (fpga_clk),
        .rst_n       (rst_n),
        .pi_clk      (pi_clk),
        .data_in     (data_in),
        .err_clr     (err_clr),
        .pix         (pix_if),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #10 fpga_clk = ~fpga_clk;

    typedef struct packed {
        logic [23:0] hsv;
        logic [5:0]  row;
        logic [5:0]  col;
        logic        last;
    } xfer_t;

    int    errors = 0;
    int    checks = 0;
    xfer_t mon_q[$];

    // Transfer monitor: valid && ready seen mid-cycle completes on the next edge.
    always @(negedge fpga_clk) begin
        xfer_t x;
        if (rst_n && pix_if.pixel_valid && pix_if.pixel_ready) begin
            x.hsv  = pix_if.pixel_hsv;
            x.row  = pix_if.pixel_row;
            x.col  = pix_if.pixel_col;
            x.last = pix_if.pixel_last;
            mon_q.push_back(x);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fpga_clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_xfer(input string name, input int idx, input xfer_t exp);
        if (idx >= mon_q.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: transfer %0d missing, only %0d seen", name, idx, mon_q.size());
        end else begin
            check({name, ".hsv"},  32'(mon_q[idx].hsv),  32'(exp.hsv));
            check({name, ".row"},  32'(mon_q[idx].row),  32'(exp.row));
            check({name, ".col"},  32'(mon_q[idx].col),  32'(exp.col));
            check({name, ".last"}, 32'(mon_q[idx].last), 32'(exp.last));
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        pi_clk  = 1'b1;
        tick(HALF);
        pi_clk  = 1'b0;
        tick(HALF);
    endtask

    task automatic send_bits(input logic [23:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send_bit(w[i]);
        end
    endtask

    task automatic send_pixel(input logic [23:0] w);
        send_bits(w, 0, 23);
    endtask

    task automatic do_reset();
        pi_clk  = 1'b0;
        data_in = 1'b0;
        err_clr = 1'b0;
        rst_n   = 1'b0;
        tick(3);
        rst_n   = 1'b1;
        tick(2);
        mon_q.delete();
    endtask

    function automatic xfer_t mk(input logic [23:0] h, input int r, input int c, input logic l);
        xfer_t x;
        x.hsv  = h;
        x.row  = 6'(r);
        x.col  = 6'(c);
        x.last = l;
        return x;
    endfunction

    xfer_t       vecs[5];
    int          lat;
    logic [23:0] w;

    initial begin
        vecs[0] = mk(24'hABCDEF, 0, 1, 1'b0);
        vecs[1] = mk(24'hFFFFFF, 0, 2, 1'b0);
        vecs[2] = mk(24'h000000, 0, 3, 1'b0);
        vecs[3] = mk(24'h800001, 0, 4, 1'b0);
        vecs[4] = mk(24'h5A5A5A, 1, 0, 1'b0);

        // Reset state.
        pix_if.pixel_ready = 1'b1;
        rst_n = 1'b0;
        tick(2);
        check("rst.valid",   32'(pix_if.pixel_valid), 32'd0);
        check("rst.hsv",     32'(pix_if.pixel_hsv),   32'd0);
        check("rst.row",     32'(pix_if.pixel_row),   32'd0);
        check("rst.col",     32'(pix_if.pixel_col),   32'd0);
        check("rst.last",    32'(pix_if.pixel_last),  32'd0);
        check("rst.overrun", 32'(overrun),            32'd0);
        check("rst.timeout", 32'(timeout_err),        32'd0);
        rst_n = 1'b1;
        tick(2);
        mon_q.delete();

        // First pixel with latency measured from the 24th pin rising edge.
        w = 24'h194A30;
        send_bits(w, 0, 22);
        data_in = w[23];
        pi_clk  = 1'b1;
        lat     = 0;
        for (int i = 1; i <= HALF; i++) begin
            tick(1);
            if (pix_if.pixel_valid && (lat == 0)) lat = i;
        end
        pi_clk = 1'b0;
        tick(HALF);
        check("latency", 32'(lat), 32'd7);
        check("first.count", 32'(mon_q.size()), 32'd1);
        check_xfer("first", 0, mk(24'h194A30, 0, 0, 1'b0));
        check("first.valid_drop", 32'(pix_if.pixel_valid), 32'd0);

        // Table-driven pixels with ready held high.
        for (int i = 0; i < 5; i++) begin
            send_pixel(vecs[i].hsv);
        end
        for (int i = 0; i < 5; i++) begin
            check_xfer($sformatf("tbl%0d", i), i + 1, vecs[i]);
        end

        // Backpressure: second pixel dropped, first held stable.
        do_reset();
        pix_if.pixel_ready = 1'b0;
        send_pixel(24'h000001);
        send_pixel(24'h000002);
        check("ovr.valid",   32'(pix_if.pixel_valid), 32'd1);
        check("ovr.hsv",     32'(pix_if.pixel_hsv),   32'h000001);
        check("ovr.col",     32'(pix_if.pixel_col),   32'd0);
        check("ovr.flag",    32'(overrun),            32'd1);
        tick(5);
        check("ovr.stable",  32'(pix_if.pixel_hsv),   32'h000001);
        check("ovr.noxfer",  32'(mon_q.size()),       32'd0);
        pix_if.pixel_ready = 1'b1;
        tick(2);
        check("ovr.drained", 32'(pix_if.pixel_valid), 32'd0);
        check_xfer("ovr.x0", 0, mk(24'h000001, 0, 0, 1'b0));
        send_pixel(24'h000003);
        check_xfer("ovr.x1", 1, mk(24'h000003, 0, 2, 1'b0));
        check("ovr.sticky",  32'(overrun),            32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("ovr.clr",     32'(overrun),            32'd0);

        // Full frame plus one: last only on the final position, then wrap.
        do_reset();
        for (int i = 0; i <= TB_LENGTH * TB_WIDTH; i++) begin
            send_pixel(24'(i * 7 + 1));
        end
        check("frame.count", 32'(mon_q.size()), 32'(TB_LENGTH * TB_WIDTH + 1));
        for (int i = 0; i <= TB_LENGTH * TB_WIDTH; i++) begin
            check_xfer($sformatf("frame%0d", i), i,
                       mk(24'(i * 7 + 1), (i / TB_WIDTH) % TB_LENGTH, i % TB_WIDTH,
                          (i == TB_LENGTH * TB_WIDTH - 1)));
        end

        // Two-cycle glitch on pi_clk during a low phase is ignored.
        do_reset();
        w = 24'h3C5A96;
        send_bits(w, 0, 5);
        data_in = 1'b1;
        tick(2);
        pi_clk = 1'b1;
        tick(2);
        pi_clk = 1'b0;
        tick(HALF);
        send_bits(w, 6, 23);
        check("glitch.count", 32'(mon_q.size()), 32'd1);
        check_xfer("glitch", 0, mk(24'h3C5A96, 0, 0, 1'b0));

        // Mid-pixel idle.
        do_reset();
        w = 24'hABCDEF;
        send_bits(w, 0, 9);
        tick(TB_TIMEOUT + 100);
`ifdef HSV_PIXEL_RX_TIMEOUT_EN
        check("tout.flag",   32'(timeout_err),  32'd1);
        check("tout.noxfer", 32'(mon_q.size()), 32'd0);
        send_pixel(w);
        check_xfer("tout.next", 0, mk(24'hABCDEF, 0, 0, 1'b0));
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("tout.clr",    32'(timeout_err),  32'd0);
`else
        check("idle.noflag", 32'(timeout_err),  32'd0);
        send_bits(w, 10, 23);
        check_xfer("idle.resume", 0, mk(24'hABCDEF, 0, 0, 1'b0));
        check("idle.noflag2", 32'(timeout_err), 32'd0);
`endif

        // Asynchronous reset mid-pixel with a held pixel and overrun set.
        do_reset();
        pix_if.pixel_ready = 1'b0;
        send_pixel(24'h123456);
        send_pixel(24'h654321);
        send_bits(24'hFEDCBA, 0, 11);
        check("arst.pre_valid", 32'(pix_if.pixel_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst.valid",   32'(pix_if.pixel_valid), 32'd0);
        check("arst.hsv",     32'(pix_if.pixel_hsv),   32'd0);
        check("arst.overrun", 32'(overrun),            32'd0);
        tick(3);
        rst_n = 1'b1;
        pix_if.pixel_ready = 1'b1;
        tick(2);
        mon_q.delete();
        send_pixel(24'h0F1E2D);
        check("arst.count", 32'(mon_q.size()), 32'd1);
        check_xfer("arst.next", 0, mk(24'h0F1E2D, 0, 0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hsv_pixel_rx.md
# hsv_pixel_rx

Serial front end of the RPS classifier. Takes the Raspberry Pi's bit clock and data line as asynchronous pins and brings them into the `fpga_clk` domain with synchronisers and a glitch filter. Assembles 24-bit HSV pixels LSB-first and presents each one with its row/column position over a valid/ready handshake to the downstream hand-mask/classifier stage. It replaces the slow-clock debounce and the use of `pi_clk` as a clock.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth for `pi_clk` and `data_in` (minimum 2).
- `FILTER_LEN`, 4: consecutive identical samples required before the filtered `pi_clk` level changes.
- `LENGTH`, 40: image rows.
- `WIDTH`, 60: image columns.
- `TIMEOUT_CYCLES`, 50000: idle `fpga_clk` cycles mid-pixel before the partial pixel is discarded.

Ports:
- `fpga_clk` in 1: system clock (50 MHz); the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pi_clk` in 1: Pi bit clock, asynchronous pin.
- `data_in` in 1: Pi serial data, asynchronous pin.
- `err_clr` in 1: synchronous clear of the sticky error flags.
- `pixel_ready` in 1: downstream can accept.
- `pixel_valid` out 1: output register holds a pixel.
- `pixel_hsv` out 24: [7:0] hue, [15:8] saturation, [23:16] value.
- `pixel_row` out 6: row of the held pixel, 0..LENGTH-1.
- `pixel_col` out 6: column of the held pixel, 0..WIDTH-1.
- `pixel_last` out 1: held pixel is (LENGTH-1, WIDTH-1).
- `overrun` out 1: sticky; a pixel was dropped.
- `timeout_err` out 1: sticky; a partial pixel was discarded.

## Operation
- **Synchronisers:** `pi_clk` and `data_in` each pass through `SYNC_STAGES` flops.
- **Glitch filter:**
  - The filtered clock level changes only after `FILTER_LEN` consecutive synchronised samples differ from the current level.
  - A run shorter than that resets the filter counter.
  - The filter counter saturates.
- **Bit capture:**
  - A rising edge of the filtered clock captures the synchronised `data_in`, delayed by `FILTER_LEN` flops so it stays aligned with the filtered clock, into `shift[bit_cnt]`.
  - `bit_cnt` counts 0..23.
- **Receive FSM:**
  - RX_IDLE (`bit_cnt`=0) → RX_SHIFT on the first captured bit.
  - RX_SHIFT → RX_IDLE on the 24th bit; the pixel completes.
  - RX_SHIFT → RX_IDLE on timeout (see Configuration).
- **Pixel completion:**
  - If the output register is empty, or is being drained this cycle (`pixel_valid && pixel_ready`), load `hsv`, `row`, `col` and `last`.
  - Otherwise the new pixel is dropped and `overrun` is set.
  - The position counters advance in both cases, so frame alignment with the Pi is kept.
- **Position counters:**
  - `col` increments per completed pixel and wraps from WIDTH-1 to 0, incrementing `row`.
  - `row` wraps from LENGTH-1 to 0.
  - A frame is exactly LENGTH*WIDTH pixels.
- **Handshake:**
  - Transfer happens on a cycle with `pixel_valid && pixel_ready`.
  - `pixel_valid` stays high and the payload is stable until transfer.
  - `pixel_ready` may be tied high.
- **Sticky flags:** `err_clr` clears `overrun` and `timeout_err`. If an error event occurs in the same cycle as `err_clr`, the event wins and the flag stays 1.

## Timing
- Reset values:
  - All outputs 0, `bit_cnt` 0, `row`/`col` 0, FSM RX_IDLE.
  - Filter level 0 and synchroniser flops 0.
  - `rst_n` asserted mid-pixel discards everything immediately (asynchronous).
- Latency: the 24th `pi_clk` rising edge at the pin gives `pixel_valid` high SYNC_STAGES + FILTER_LEN + 1 `fpga_clk` cycles later (7 with defaults).
- Throughput: one pixel per 24 Pi bits. The output register is single-entry; back-to-back completion plus a drain in the same cycle is lossless.
- Pi constraint: high and low phases of `pi_clk` each ≥ FILTER_LEN + 2 `fpga_clk` cycles. Data must be stable from the rising edge to the next falling edge.
- Pulses on `pi_clk` shorter than FILTER_LEN cycles are ignored entirely.

## Configuration
- Macro: `HSV_PIXEL_RX_TIMEOUT_EN`.
- **Defined:**
  - An idle counter runs in RX_SHIFT and is cleared on each captured bit.
  - When it reaches TIMEOUT_CYCLES, `bit_cnt` clears, the FSM returns to RX_IDLE and `timeout_err` is set.
  - Position counters are unchanged.
- **Undefined:** no counter. A partial pixel persists indefinitely, and `timeout_err` is tied 0.

## Structure
- **Package `rps_pkg`:**
  - `LENGTH`, `WIDTH`, `HSV_BITS`=24.
  - `hsv_t` packed struct {value, saturation, hue}, 8 bits each.
  - `rx_state_t` enum.
  - This package is shared with the mask/classifier stage.
- **Sub-module `sync_glitch_filter`:** one instance for `pi_clk`. It outputs the filtered level and a one-cycle rising-edge pulse. The `data_in` synchroniser and delay line stay in the top.

## Test plan
- After reset, with `pixel_ready`=1, send 0x194A30 LSB-first → one-cycle `pixel_valid`, `pixel_hsv`=0x194A30, row 0, col 0, `pixel_last`=0, latency 7 cycles.
- With `pixel_ready`=0, send two pixels 0x000001 and 0x000002 → first held stable and `overrun`=1. Raise ready → 0x000001 transfers. A third pixel then arrives at col 2.
- Send 2400 pixels → `pixel_last`=1 only at row 39, col 59. Pixel 2401 arrives at row 0, col 0.
- Send a 2-cycle high glitch on `pi_clk` between bits (FILTER_LEN=4) → no bit captured, and the pixel value is unaffected.
- With the macro defined, send 10 bits, then idle 50000 cycles → `timeout_err`=1. A following 0xABCDEF is received correctly. Assert `err_clr` → flag clears.
- Pulse `rst_n` low after 12 bits → all outputs 0 immediately. The next 24 bits give a pixel at row 0, col 0.
